// File: rtl/cbus_arbiter_n_pkg.sv
// Shared cbus types and constants for the N-master arbiter.
// Build option: CBUS_ARB_RR_EN selects the round-robin picker (see rr_priority_picker).
package cbus_arbiter_n_pkg;

  parameter int unsigned CBUS_ARB_MAX_MASTERS = 8;
  parameter int unsigned CBUS_ADDR_W          = 32;
  parameter int unsigned CBUS_DATA_W          = 32;

  typedef enum logic {ARB_IDLE, ARB_BUSY} cbus_arb_state_t;

  // Burst length is encoded as beats-1, so it equals the beat counter on the last beat.
  typedef enum logic [7:0] {
    MLEN1  = 8'd0,
    MLEN2  = 8'd1,
    MLEN4  = 8'd3,
    MLEN8  = 8'd7,
    MLEN16 = 8'd15
  } cbus_mlen_t;

  typedef struct packed {
    logic                     valid;
    logic                     is_write;
    logic [CBUS_ADDR_W-1:0]   addr;
    logic [CBUS_DATA_W-1:0]   wdata;
    logic [CBUS_DATA_W/8-1:0] wstrb;
    cbus_mlen_t               len;
  } cbus_req_t;

  typedef struct packed {
    logic                   ready;
    logic                   last;
    logic [CBUS_DATA_W-1:0] rdata;
  } cbus_resp_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational request picker: round-robin from ptr when CBUS_ARB_RR_EN is defined,
// otherwise fixed priority with the lowest index winning.
module rr_priority_picker
  import cbus_arbiter_n_pkg::*;
#(
  parameter int unsigned N = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] idx,
  output logic             rr_en
);

`ifdef CBUS_ARB_RR_EN
  logic [IDX_W:0] w_sum;

  assign rr_en = 1'b1;

  // Scan upward from ptr with wrap; the first valid candidate wins.
  always_comb begin
    any   = 1'b0;
    idx   = '0;
    w_sum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      if (!any && req[IDX_W'(w_sum)]) begin
        any = 1'b1;
        idx = IDX_W'(w_sum);
      end
    end
  end
`else
  logic w_unused_ptr;

  assign rr_en        = 1'b0;
  assign w_unused_ptr = ^ptr;

  always_comb begin
    any = 1'b0;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any && req[i]) begin
        any = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/cbus_arbiter_n.sv
// N-master to 1 cbus arbiter with burst-atomic grants and a one-cycle bubble between bursts.
// Build option: CBUS_ARB_RR_EN (round-robin picker; fixed priority when undefined).
module cbus_arbiter_n
  import cbus_arbiter_n_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  localparam int unsigned IDX_W = $clog2(NUM_MASTERS)
) (
  input  logic             clk,
  input  logic             reset,
  input  cbus_req_t        ireqs  [NUM_MASTERS],
  output cbus_resp_t       iresps [NUM_MASTERS],
  output cbus_req_t        oreq,
  input  cbus_resp_t       oresp,
  output logic             busy,
  output logic [IDX_W-1:0] grant_idx
);

  if (NUM_MASTERS < 2 || NUM_MASTERS > CBUS_ARB_MAX_MASTERS) begin : g_bad_cfg
    $error("cbus_arbiter_n: NUM_MASTERS out of range");
  end

  cbus_arb_state_t  r_state;
  cbus_arb_state_t  w_state_next;
  logic [IDX_W-1:0] r_grant_idx;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] w_ptr_next;
  logic [7:0]       r_beat_cnt;

  logic [NUM_MASTERS-1:0] w_req_valid;
  logic                   w_pick_any;
  logic [IDX_W-1:0]       w_pick_idx;
  logic                   w_rr_en;
  cbus_req_t              w_gnt_req;
  logic                   w_grant;
  logic                   w_burst_done;

  always_comb begin
    w_req_valid = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      w_req_valid[i] = ireqs[i].valid;
    end
  end

  rr_priority_picker #(
    .N (NUM_MASTERS)
  ) u_picker (
    .req   (w_req_valid),
    .ptr   (r_rr_ptr),
    .any   (w_pick_any),
    .idx   (w_pick_idx),
    .rr_en (w_rr_en)
  );

  assign w_gnt_req    = ireqs[r_grant_idx];
  assign w_grant      = (r_state == ARB_IDLE) && w_pick_any;
  assign w_burst_done = (r_state == ARB_BUSY) && oresp.ready && oresp.last;
  assign w_ptr_next   = IDX_W'(wrap_inc(32'(r_grant_idx), NUM_MASTERS));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ARB_IDLE: if (w_pick_any) w_state_next = ARB_BUSY;
      ARB_BUSY: if (oresp.ready && oresp.last) w_state_next = ARB_IDLE;
      default:  w_state_next = ARB_IDLE;
    endcase
  end

  // Grant index, fairness pointer and beat counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_grant_idx <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
    end else begin
      if (w_grant) begin
        r_grant_idx <= w_pick_idx;
        r_beat_cnt  <= '0;
      end else if (r_state == ARB_BUSY && oresp.ready) begin
        r_beat_cnt <= r_beat_cnt + 8'd1;
      end
      // Fixed-priority builds keep the pointer at zero so it folds away.
      if (w_burst_done) begin
        r_rr_ptr <= w_rr_en ? w_ptr_next : '0;
      end
    end
  end

  // Outputs: only the granted master is connected, and only while busy.
  always_comb begin
    oreq = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      iresps[i] = '0;
    end
    if (r_state == ARB_BUSY && !reset) begin
      oreq                 = w_gnt_req;
      iresps[r_grant_idx]  = oresp;
    end
  end

  assign busy      = (r_state == ARB_BUSY);
  assign grant_idx = r_grant_idx;

`ifndef SYNTHESIS
  a_last_matches_len: assert property (@(posedge clk) disable iff (reset)
    (r_state == ARB_BUSY && oresp.ready && oresp.last) |-> (r_beat_cnt == 8'(w_gnt_req.len)));

  a_master_holds_valid: assert property (@(posedge clk) disable iff (reset)
    (r_state == ARB_BUSY) |-> w_gnt_req.valid);

  a_no_ready_in_idle: assert property (@(posedge clk) disable iff (reset)
    (r_state == ARB_IDLE) |-> !oresp.ready);
`endif

endmodule

// File: tb/tb_cbus_arbiter_n.sv
// Scoreboard bench for cbus_arbiter_n with three masters and a simple burst bridge model.
// Expected grants are queued by the stimulus and retired by the monitor on each new grant.
module tb_cbus_arbiter_n;
  import cbus_arbiter_n_pkg::*;

  localparam int unsigned NM = 3;
  localparam int unsigned IW = $clog2(NM);

`ifdef CBUS_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  typedef struct {
    int idx;
    bit is_write;
    int len;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  cbus_req_t  ireqs  [NM];
  cbus_resp_t iresps [NM];
  cbus_req_t  oreq;
  cbus_resp_t oresp;
  logic          busy;
  logic [IW-1:0] grant_idx;

  int   checks   = 0;
  int   failures = 0;
  exp_t exp_q[$];
  int   left [NM];
  bit   done_pend [NM];
  exp_t cur;
  bit   cur_valid;
  int   cur_beats;
  int   idle_cnt;
  bit   prev_busy;
  int   br_beat;
  bit   br_rst;

  cbus_arbiter_n #(
    .NUM_MASTERS (NM)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ireqs     (ireqs),
    .iresps    (iresps),
    .oreq      (oreq),
    .oresp     (oresp),
    .busy      (busy),
    .grant_idx (grant_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input bit w, input int len, input int gap);
    exp_t e;
    e.idx = idx;
    e.is_write = w;
    e.len = len;
    e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic cfg(input int i, input bit w, input cbus_mlen_t len);
    ireqs[i].is_write = w;
    ireqs[i].len      = len;
    ireqs[i].addr     = 32'h1000 * (i + 1);
    ireqs[i].wdata    = 32'hD000_0000 + i;
    ireqs[i].wstrb    = '1;
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    int quiet = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (!busy && left[0] == 0 && left[1] == 0 && left[2] == 0) quiet++;
      else quiet = 0;
    end
    check(name, 64'(quiet >= 3), 64'd1);
  endtask

  task automatic wait_beats(input string name, input int target, input int budget);
    int n = 0;
    while (!(cur_valid && cur_beats >= target) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 64'(cur_valid && cur_beats >= target), 64'd1);
  endtask

  // Masters: hold valid while bursts remain; a burst retires on the edge its last beat is taken.
  initial begin
    forever begin
      @(posedge clk); #1;
      for (int i = 0; i < NM; i++) begin
        if (done_pend[i]) begin
          done_pend[i] = 1'b0;
          if (left[i] > 0) left[i]--;
        end
        ireqs[i].valid = (left[i] > 0);
      end
    end
  end

  // Bridge: answers every cycle oreq.valid is high, last on beat len.
  initial begin
    oresp   = '0;
    br_beat = 0;
    forever begin
      @(posedge clk);
      br_rst = reset;
      #2;
      if (br_rst) br_beat = 0;
      else if (oresp.ready) br_beat = oresp.last ? 0 : br_beat + 1;
      if (!reset && oreq.valid) begin
        oresp.ready = 1'b1;
        oresp.last  = (br_beat == int'(oreq.len));
        oresp.rdata = {24'h5A5A5A, 8'(br_beat)};
      end else begin
        oresp = '0;
      end
    end
  end

  // Monitor: retire one expected grant per busy rise, check routing on every beat.
  initial begin
    cur_valid = 1'b0;
    prev_busy = 1'b0;
    idle_cnt  = 0;
    cur_beats = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_oreq_valid", 64'(oreq.valid), 64'd0);
        cur_valid = 1'b0;
        prev_busy = 1'b0;
        idle_cnt  = 0;
      end else begin
        if (busy && !prev_busy) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL grant_unexpected: got grant to %0d, required none", grant_idx);
            cur_valid = 1'b0;
          end else begin
            cur       = exp_q.pop_front();
            cur_valid = 1'b1;
            cur_beats = 0;
            check("grant_idx", 64'(grant_idx), 64'(cur.idx));
            check("grant_len", 64'(int'(oreq.len)), 64'(cur.len));
            if (cur.gap >= 0) check("idle_gap", 64'(idle_cnt), 64'(cur.gap));
          end
          idle_cnt = 0;
        end
        if (!busy && prev_busy && cur_valid) begin
          check("burst_beats", 64'(cur_beats), 64'(cur.len + 1));
          cur_valid = 1'b0;
        end
        if (busy && cur_valid) begin
          check("oreq_is_write", 64'(oreq.is_write), 64'(cur.is_write));
          check("oreq_addr", 64'(oreq.addr), 64'(32'h1000 * (cur.idx + 1)));
        end
        for (int i = 0; i < NM; i++) begin
          if (iresps[i].ready) begin
            check("resp_route", 64'(i), cur_valid ? 64'(cur.idx) : -64'sd1);
            if (iresps[i].last) done_pend[i] = 1'b1;
            if (cur_valid && i == cur.idx) begin
              check("resp_beat", 64'(iresps[i].rdata), 64'({24'h5A5A5A, 8'(cur_beats)}));
              cur_beats++;
            end
          end
        end
        if (!busy) idle_cnt++;
        prev_busy = busy;
      end
    end
  end

  initial begin
    logic any_resp;
    reset = 1'b1;
    for (int i = 0; i < NM; i++) begin
      ireqs[i]     = '0;
      left[i]      = 0;
      done_pend[i] = 1'b0;
      cfg(i, 1'b0, MLEN4);
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clk);
      any_resp = 1'b0;
      for (int i = 0; i < NM; i++) any_resp = any_resp | (|iresps[i]);
      check("idle_busy", 64'(busy), 64'd0);
      check("idle_oreq_valid", 64'(oreq.valid), 64'd0);
      check("idle_iresps_zero", 64'(any_resp), 64'd0);
    end
    check("reset_grant_idx", 64'(grant_idx), 64'd0);
    check("reset_rr_ptr", 64'(dut.r_rr_ptr), 64'd0);

    // Single master m1, 16-beat read
    cfg(1, 1'b0, MLEN16);
    push(1, 1'b0, 15, -1);
    left[1] = 1;
    @(posedge clk);
    @(negedge clk);
    check("latency_req_cycle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("latency_next_cycle_busy", 64'(busy), 64'd1);
    wait_idle("m1_burst_done", 200);
    check("rr_ptr_after_m1", 64'(dut.r_rr_ptr), RrEn ? 64'd2 : 64'd0);

    // All three request together and hold valid
    pulse_reset();
    for (int i = 0; i < NM; i++) cfg(i, 1'b0, MLEN4);
    if (RrEn) begin
      push(0, 1'b0, 3, -1);
      push(1, 1'b0, 3, 1);
      push(2, 1'b0, 3, 1);
      push(0, 1'b0, 3, 1);
    end else begin
      push(0, 1'b0, 3, -1);
      push(0, 1'b0, 3, 1);
      push(1, 1'b0, 3, 1);
      push(2, 1'b0, 3, 1);
    end
    left[0] = 2;
    left[1] = 1;
    left[2] = 1;
    wait_idle("contention_done", 300);
    check("rr_ptr_after_contention", 64'(dut.r_rr_ptr), RrEn ? 64'd1 : 64'd0);

    // m0 arrives mid-way through m2's write burst
    pulse_reset();
    cfg(2, 1'b1, MLEN8);
    push(2, 1'b1, 7, -1);
    left[2] = 1;
    wait_beats("m2_reach_beat3", 3, 100);
    cfg(0, 1'b0, MLEN4);
    push(0, 1'b0, 3, 1);
    left[0] = 1;
    wait_idle("late_request_done", 200);

    // Reset in the middle of m1's 8-beat burst
    pulse_reset();
    cfg(1, 1'b0, MLEN8);
    cfg(2, 1'b0, MLEN4);
    push(1, 1'b0, 7, -1);
    push(1, 1'b0, 7, -1);
    push(2, 1'b0, 3, 1);
    left[1] = 1;
    left[2] = 1;
    wait_beats("m1_reach_beat5", 5, 100);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("post_reset_busy", 64'(busy), 64'd0);
    check("post_reset_oreq_valid", 64'(oreq.valid), 64'd0);
    check("post_reset_grant_idx", 64'(grant_idx), 64'd0);
    wait_idle("after_reset_done", 300);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
